pipeline_ctrl: RTL

Central stall/flush sequencer for the 8-stage pipeline (IF, IDC, IDR, EXB, EXA, MEMP, MEMR, WB). It merges data-hazard requests from the forwarding unit, the data-memory wait from MEMP, the taken-redirect from EXA and instruction-fetch busy into per-pipeline-register hold/bubble controls. It also tracks the memory wait with a timeout FSM, discards stale fetch responses after a redirect, and keeps stall/flush performance counters.

---
 rtl/pipeline_ctrl.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/flush sequencer for the 8-stage pipeline
// (IF, IDC, IDR, EXB, EXA, MEMP, MEMR, WB). It merges the hazard, memory-wait,
// redirect and fetch-busy causes into per-register hold/bubble controls. It
// also supervises the data-memory wait with a timeout FSM, discards the stale
// fetch response after a redirect, and keeps stall/flush performance counters.
module pipeline_ctrl #(
   parameter int unsigned MEM_TIMEOUT = 255,
   parameter int unsigned CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             hazard_IDR,
   input  logic             hazard_EXB,
   input  logic             hazard_MEMP,
   input  logic             if_busy,
   input  logic             redirect_EXA,
   input  logic             dm_req_MEMP,
   input  logic             dm_ack,
   output logic [7:0]       stall,
   output logic [7:0]       flush,
   output logic             pc_redirect,
   output logic             mem_wait,
   output logic             mem_timeout,
   output logic [CNT_W-1:0] cnt_data_stall,
   output logic [CNT_W-1:0] cnt_mem_stall,
   output logic [CNT_W-1:0] cnt_flush
);

   localparam logic [16:0] TIMEOUT_LIMIT = {1'b0, 16'(MEM_TIMEOUT)};

   // Winning cause for the current cycle, in priority order.
   typedef enum logic [2:0] {
      CAUSE_RESET,
      CAUSE_MEM,
      CAUSE_REDIRECT,
      CAUSE_KILL,
      CAUSE_DATA,
      CAUSE_FETCH,
      CAUSE_NONE
   } cause_t;

   typedef enum logic {
      ST_IDLE,
      ST_WAIT
   } mem_state_t;

   logic             mem_stall;
   logic             data_hz;
   cause_t           cause;

   mem_state_t       mem_state_q, mem_state_d;
   logic [15:0]      wait_cnt_q, wait_cnt_d;
   logic             mem_timeout_q, mem_timeout_d;
   logic             kill_pending_q, kill_pending_d;
   logic [CNT_W-1:0] cnt_data_stall_q, cnt_data_stall_d;
   logic [CNT_W-1:0] cnt_mem_stall_q, cnt_mem_stall_d;
   logic [CNT_W-1:0] cnt_flush_q, cnt_flush_d;

   assign mem_stall = dm_req_MEMP & ~dm_ack;
   assign data_hz   = hazard_IDR | hazard_EXB | hazard_MEMP;

   // Select the highest-priority active cause.
   always_comb begin
      cause = CAUSE_NONE;
      if (rst) begin
         cause = CAUSE_RESET;
      end else if (mem_stall) begin
         cause = CAUSE_MEM;
      end else if (redirect_EXA) begin
         cause = CAUSE_REDIRECT;
      end else if (kill_pending_q && !if_busy) begin
         cause = CAUSE_KILL;
      end else if (data_hz) begin
         cause = CAUSE_DATA;
      end else if (if_busy) begin
         cause = CAUSE_FETCH;
      end
   end

   // Decode the winning cause into hold/bubble controls.
   always_comb begin
      stall       = '0;
      flush       = '0;
      pc_redirect = 1'b0;
      case (cause)
         CAUSE_RESET: begin
            flush = 8'hFE;
         end
         CAUSE_MEM: begin
            // Hold everything up to MEMP, feed a bubble into MEMR.
            stall = 8'h3F;
            flush = 8'h40;
         end
         CAUSE_REDIRECT: begin
            // Squash the four younger instructions IDC..EXA.
            pc_redirect = 1'b1;
            flush       = 8'h1E;
         end
         CAUSE_KILL: begin
            flush = 8'h02;
         end
         CAUSE_DATA: begin
            stall = 8'h03;
            flush = 8'h04;
         end
         CAUSE_FETCH: begin
            stall = 8'h01;
            flush = 8'h02;
         end
         default: begin
            stall = '0;
            flush = '0;
         end
      endcase
   end

   // Track a fetch response that belongs to the path discarded by a redirect.
   always_comb begin
      kill_pending_d = kill_pending_q;
      if (cause == CAUSE_REDIRECT) begin
         kill_pending_d = kill_pending_q | if_busy;
      end else if (cause == CAUSE_KILL) begin
         kill_pending_d = 1'b0;
      end
   end

   // Memory-wait FSM next state with wait counter and sticky timeout.
   always_comb begin
      mem_state_d   = mem_state_q;
      wait_cnt_d    = wait_cnt_q;
      mem_timeout_d = mem_timeout_q;
      case (mem_state_q)
         ST_IDLE: begin
            if (mem_stall) begin
               mem_state_d = ST_WAIT;
               wait_cnt_d  = '0;
            end
         end
         ST_WAIT: begin
            if (wait_cnt_q != '1) begin
               wait_cnt_d = wait_cnt_q + 16'd1;
            end
            if (({1'b0, wait_cnt_q} + 17'd1) >= TIMEOUT_LIMIT) begin
               mem_timeout_d = 1'b1;
            end
            if (dm_ack) begin
               mem_state_d = ST_IDLE;
            end
         end
         default: begin
            mem_state_d = ST_IDLE;
         end
      endcase
   end

   // Performance counter next values (wrap naturally at 2^CNT_W).
   always_comb begin
      cnt_data_stall_d = cnt_data_stall_q;
      cnt_mem_stall_d  = cnt_mem_stall_q;
      cnt_flush_d      = cnt_flush_q;
      if (cause == CAUSE_DATA) begin
         cnt_data_stall_d = cnt_data_stall_q + CNT_W'(1);
      end
      if (cause == CAUSE_MEM) begin
         cnt_mem_stall_d = cnt_mem_stall_q + CNT_W'(1);
      end
      if (cause == CAUSE_REDIRECT) begin
         cnt_flush_d = cnt_flush_q + CNT_W'(1);
      end
   end

   // State registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_state_q      <= ST_IDLE;
         wait_cnt_q       <= '0;
         mem_timeout_q    <= 1'b0;
         kill_pending_q   <= 1'b0;
         cnt_data_stall_q <= '0;
         cnt_mem_stall_q  <= '0;
         cnt_flush_q      <= '0;
      end else begin
         mem_state_q      <= mem_state_d;
         wait_cnt_q       <= wait_cnt_d;
         mem_timeout_q    <= mem_timeout_d;
         kill_pending_q   <= kill_pending_d;
         cnt_data_stall_q <= cnt_data_stall_d;
         cnt_mem_stall_q  <= cnt_mem_stall_d;
         cnt_flush_q      <= cnt_flush_d;
      end
   end

   assign mem_wait       = (mem_state_q == ST_WAIT);
   assign mem_timeout    = mem_timeout_q;
   assign cnt_data_stall = cnt_data_stall_q;
   assign cnt_mem_stall  = cnt_mem_stall_q;
   assign cnt_flush      = cnt_flush_q;

endmodule
